// File: rtl/fifo_wr_arbiter.sv
// Packet-level round-robin arbiter for the async FIFO write port.
// Owns the grant for a whole packet and only writes when the FIFO is not full.
module fifo_wr_arbiter #(
   parameter int NREQ   = 4,
   parameter int DWIDTH = 8,
   parameter int CNTW   = 16
) (
   input  logic                     wclk,
   input  logic                     wr_srstn,
   input  logic [NREQ-1:0]          req_valid,
   input  logic [NREQ-1:0]          req_last,
   input  logic [NREQ*DWIDTH-1:0]   req_data,
   output logic [NREQ-1:0]          req_ready,
   input  logic                     full,
   output logic                     wr_en,
   output logic [DWIDTH-1:0]        wr_data,
   output logic                     wr_last,
   output logic [NREQ-1:0]          grant,
   output logic                     busy,
   output logic [CNTW-1:0]          pkt_cnt
);

   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] XFER = 1'b1;

   logic [0:0]                       state;
   logic [PW-1:0]                    rr_ptr, owner, sel_idx;
   logic                             sel_vld;
   logic [NREQ-1:0][DWIDTH-1:0]      lane_data;
   int                               idx;

   assign lane_data = req_data;
   assign busy      = (state == XFER);

   // First valid requester starting at rr_ptr, wrapping modulo NREQ.
   always_comb begin
      sel_vld = 1'b0;
      sel_idx = '0;
      idx     = 0;
      for (int k = 0; k < NREQ; k++) begin
         idx = (int'(rr_ptr) + k) % NREQ;
         if (!sel_vld && req_valid[idx]) begin
            sel_vld = 1'b1;
            sel_idx = PW'(idx);
         end
      end
   end

   for (genvar i = 0; i < NREQ; i++) begin : g_ready
      assign req_ready[i] = busy && (owner == PW'(i)) && !full;
   end

   always_comb begin
      wr_en   = busy && req_valid[owner] && !full;
      wr_data = wr_en ? lane_data[owner] : '0;
      wr_last = wr_en && req_last[owner];
   end

   always_ff @(posedge wclk or negedge wr_srstn) begin
      if (!wr_srstn) begin
         state   <= IDLE;
         grant   <= '0;
         owner   <= '0;
         rr_ptr  <= '0;
         pkt_cnt <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (sel_vld) begin
                  state <= XFER;
                  owner <= sel_idx;
                  grant <= NREQ'(1) << sel_idx;
               end
            end
            XFER: begin
               // Packet ends only on an accepted beat carrying last.
               if (wr_en && req_last[owner]) begin
                  state   <= IDLE;
                  grant   <= '0;
                  rr_ptr  <= (owner == PW'(NREQ-1)) ? '0 : owner + PW'(1);
                  pkt_cnt <= pkt_cnt + CNTW'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
